decode_stage: RTL and testbench

- Decode/register-read stage sitting directly upstream of the Execute stage.
- Takes one 16-bit instruction per cycle and reads operands from an internal 8x16 register file that also owns the writeback port.
- Produces the Execute-stage inputs src1, src2, imm, control_in and enable_ex as registered outputs.
- Instruction subset: ADD, AND, NOT, SHF, LDR, STR.

---
 rtl/exec_pkg.sv | 70 +++++++
 rtl/decode_regfile.sv | 47 ++++
 rtl/decode_stage.sv | 158 +++++++++++++++
 tb/tb_decode_stage.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared definitions for the decode and execute stages: opcodes, the
// control-word layout handed to Execute, operation encodings and helpers.
package exec_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;
  localparam int REG_AW   = 3;
  localparam int CTRL_W   = 6;

  // Opcodes live in instr[15:12]
  localparam logic [3:0] OPC_ADD = 4'b0001;
  localparam logic [3:0] OPC_AND = 4'b0101;
  localparam logic [3:0] OPC_NOT = 4'b1001;
  localparam logic [3:0] OPC_SHF = 4'b1101;
  localparam logic [3:0] OPC_LDR = 4'b0110;
  localparam logic [3:0] OPC_STR = 4'b0111;

  // Execute unit selector, control word bits [5:4]
  typedef enum logic [1:0] {
    CLASS_SHIFT = 2'b00,
    CLASS_ARITH = 2'b01,
    CLASS_LOAD  = 2'b10,
    CLASS_STORE = 2'b11
  } opClassT;

  // Arithmetic-class operations
  localparam logic [2:0] ARITH_ADD = 3'b000;
  localparam logic [2:0] ARITH_AND = 3'b001;
  localparam logic [2:0] ARITH_NOT = 3'b010;

  // Shift-class operations
  localparam logic [2:0] SHIFT_SHL = 3'b000;
  localparam logic [2:0] SHIFT_SHR = 3'b001;
  localparam logic [2:0] SHIFT_SRA = 3'b010;

  // Load/store carry no sub-operation
  localparam logic [2:0] MEM_OP = 3'b000;

  // Control word field positions
  localparam int CTRL_CLASS_HI = 5;
  localparam int CTRL_CLASS_LO = 4;
  localparam int CTRL_USE_IMM  = 3;
  localparam int CTRL_OP_HI    = 2;
  localparam int CTRL_OP_LO    = 0;

  // Assemble the Execute control word from its fields
  function automatic logic [CTRL_W-1:0] packCtrl(input opClassT cls,
                                                 input logic useImm,
                                                 input logic [2:0] op);
    logic [CTRL_W-1:0] word;
    word = '0;
    word[CTRL_CLASS_HI:CTRL_CLASS_LO] = cls;
    word[CTRL_USE_IMM]                = useImm;
    word[CTRL_OP_HI:CTRL_OP_LO]       = op;
    return word;
  endfunction

  function automatic logic [DATA_W-1:0] sext5(input logic [4:0] v);
    return {{(DATA_W-5){v[4]}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] sext6(input logic [5:0] v);
    return {{(DATA_W-6){v[5]}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] zext4(input logic [3:0] v);
    return {{(DATA_W-4){1'b0}}, v};
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// 2-read/1-write register file owned by the decode stage. All registers,
// including R0, are writable and clear on reset.
// Optional macro DECODE_WB_BYPASS_EN: a same-cycle write to a register being
// read is forwarded to the read port (write-through). Without it, reads see
// the value held before the edge that performs the write.
import exec_pkg::*;

module decode_regfile #(
  parameter int DATA_W   = exec_pkg::DATA_W,
  parameter int NUM_REGS = exec_pkg::NUM_REGS,
  parameter int REG_AW   = exec_pkg::REG_AW
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wrEn,
  input  logic [REG_AW-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic [REG_AW-1:0] rdAddrA,
  output logic [DATA_W-1:0] rdDataA,
  input  logic [REG_AW-1:0] rdAddrB,
  output logic [DATA_W-1:0] rdDataB
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Storage: clear on reset, otherwise write when enabled
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wrEn) begin
      regs[wrAddr] <= wrData;
    end
  end

  // Asynchronous read ports, optionally forwarding the pending write
  always_comb begin
    rdDataA = regs[rdAddrA];
    rdDataB = regs[rdAddrB];
`ifdef DECODE_WB_BYPASS_EN
    if (wrEn && (wrAddr == rdAddrA)) rdDataA = wrData;
    if (wrEn && (wrAddr == rdAddrB)) rdDataB = wrData;
`endif
  end

endmodule

// File: rtl/decode_stage.sv
// Decode / register-read stage feeding Execute. Decodes ADD, AND, NOT, SHF,
// LDR and STR, reads operands from decode_regfile and registers the Execute
// inputs with one cycle of latency.
// Optional macro DECODE_WB_BYPASS_EN (in decode_regfile) enables writeback
// forwarding into the operand read ports.
//
// Flow control: an instruction is accepted on a rising edge where
// instr_valid=1 and stall=0. stall=1 freezes every output register and
// ignores instr_valid, but the writeback port still writes. With stall=0 and
// instr_valid=0 only enable_ex drops; the data outputs keep their values.
import exec_pkg::*;

module decode_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] instr_in,
  input  logic        instr_valid,
  input  logic        stall,
  input  logic        wb_en,
  input  logic [2:0]  wb_addr,
  input  logic [15:0] wb_data,
  output logic [15:0] src1,
  output logic [15:0] src2,
  output logic [15:0] imm,
  output logic [5:0]  control_in,
  output logic [2:0]  dest_addr,
  output logic        enable_ex,
  output logic        illegal_op
);

  logic [3:0]  opcode;
  logic [2:0]  rdAddrA;
  logic [2:0]  rdAddrB;
  logic [15:0] rdDataA;
  logic [15:0] rdDataB;

  logic        isLegal;
  logic [15:0] nextSrc1;
  logic [15:0] nextSrc2;
  logic [15:0] nextImm;
  logic [5:0]  nextCtrl;
  logic [2:0]  nextDest;
  logic        accept;

  assign opcode  = instr_in[15:12];
  assign rdAddrA = instr_in[8:6];
  assign accept  = instr_valid && !stall;

  // STR reads its store data from the DR field; everything else uses SR2
  always_comb begin
    rdAddrB = instr_in[2:0];
    if (opcode == OPC_STR) rdAddrB = instr_in[11:9];
  end

  decode_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .REG_AW   (REG_AW)
  ) u_regfile (
    .clock   (clock),
    .reset   (reset),
    .wrEn    (wb_en),
    .wrAddr  (wb_addr),
    .wrData  (wb_data),
    .rdAddrA (rdAddrA),
    .rdDataA (rdDataA),
    .rdAddrB (rdAddrB),
    .rdDataB (rdDataB)
  );

  // Instruction decode: unused operand/immediate fields stay zero
  always_comb begin
    isLegal  = 1'b0;
    nextSrc1 = '0;
    nextSrc2 = '0;
    nextImm  = '0;
    nextCtrl = '0;
    nextDest = '0;
    case (opcode)
      OPC_ADD, OPC_AND: begin
        isLegal  = 1'b1;
        nextSrc1 = rdDataA;
        nextDest = instr_in[11:9];
        if (instr_in[5]) begin
          nextImm  = sext5(instr_in[4:0]);
          nextCtrl = packCtrl(CLASS_ARITH, 1'b1,
                              (opcode == OPC_AND) ? ARITH_AND : ARITH_ADD);
        end else begin
          nextSrc2 = rdDataB;
          nextCtrl = packCtrl(CLASS_ARITH, 1'b0,
                              (opcode == OPC_AND) ? ARITH_AND : ARITH_ADD);
        end
      end
      OPC_NOT: begin
        isLegal  = 1'b1;
        nextSrc1 = rdDataA;
        nextDest = instr_in[11:9];
        nextCtrl = packCtrl(CLASS_ARITH, 1'b0, ARITH_NOT);
      end
      OPC_SHF: begin
        isLegal  = 1'b1;
        nextSrc1 = rdDataA;
        nextDest = instr_in[11:9];
        nextImm  = zext4(instr_in[3:0]);
        nextCtrl = packCtrl(CLASS_SHIFT, 1'b1, {1'b0, instr_in[5:4]});
      end
      OPC_LDR: begin
        isLegal  = 1'b1;
        nextSrc1 = rdDataA;
        nextDest = instr_in[11:9];
        nextImm  = sext6(instr_in[5:0]);
        nextCtrl = packCtrl(CLASS_LOAD, 1'b1, MEM_OP);
      end
      OPC_STR: begin
        isLegal  = 1'b1;
        nextSrc1 = rdDataA;
        nextSrc2 = rdDataB;
        nextImm  = sext6(instr_in[5:0]);
        nextCtrl = packCtrl(CLASS_STORE, 1'b1, MEM_OP);
      end
      default: begin
        isLegal = 1'b0;
      end
    endcase
  end

  // Execute-facing output registers: accept, drop enable on idle, hold on stall
  always_ff @(posedge clock) begin
    if (reset) begin
      src1       <= '0;
      src2       <= '0;
      imm        <= '0;
      control_in <= '0;
      dest_addr  <= '0;
      enable_ex  <= 1'b0;
    end else if (accept) begin
      // decode already zeroes every field for an illegal opcode
      src1       <= nextSrc1;
      src2       <= nextSrc2;
      imm        <= nextImm;
      control_in <= nextCtrl;
      dest_addr  <= nextDest;
      enable_ex  <= isLegal;
    end else if (!stall) begin
      enable_ex  <= 1'b0;
    end
  end

  // Sticky illegal-opcode flag, cleared only by reset
  always_ff @(posedge clock) begin
    if (reset) begin
      illegal_op <= 1'b0;
    end else if (accept && !isLegal) begin
      illegal_op <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a behavioural model of the decode rules and the
// register file is checked against the DUT on every falling edge, and a set
// of hand-computed literal expectations pin the directed vectors.
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] instr_in;
  logic        instr_valid;
  logic        stall;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic [15:0] src1;
  logic [15:0] src2;
  logic [15:0] imm;
  logic [5:0]  control_in;
  logic [2:0]  dest_addr;
  logic        enable_ex;
  logic        illegal_op;

  int total = 0;
  int bad   = 0;

  // clock / reset block
  always #5 clock = ~clock;

  initial begin
    reset       = 1'b1;
    instr_in    = '0;
    instr_valid = 1'b0;
    stall       = 1'b0;
    wb_en       = 1'b0;
    wb_addr     = '0;
    wb_data     = '0;
  end

  decode_stage dut (
    .clock       (clock),
    .reset       (reset),
    .instr_in    (instr_in),
    .instr_valid (instr_valid),
    .stall       (stall),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .src1        (src1),
    .src2        (src2),
    .imm         (imm),
    .control_in  (control_in),
    .dest_addr   (dest_addr),
    .enable_ex   (enable_ex),
    .illegal_op  (illegal_op)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] mRegs [8];
  logic [15:0] mSrc1, mSrc2, mImm;
  logic [5:0]  mCtrl;
  logic [2:0]  mDest;
  logic        mEn, mIll;
  bit          modelLive = 0;

  function automatic logic [15:0] readReg(input logic [2:0] a);
`ifdef DECODE_WB_BYPASS_EN
    if (wb_en && wb_addr == a) return wb_data;
`endif
    return mRegs[a];
  endfunction

  function automatic logic [15:0] signExt(input logic [15:0] v, input int bits);
    logic [15:0] r;
    r = v & ((16'd1 << bits) - 16'd1);
    if (v[bits-1]) r = r | ~((16'd1 << bits) - 16'd1);
    return r;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) mRegs[i] = '0;
      mSrc1 = '0; mSrc2 = '0; mImm = '0; mCtrl = '0; mDest = '0;
      mEn = 1'b0; mIll = 1'b0;
      modelLive = 1;
    end else begin
      if (!stall && instr_valid) begin
        logic [15:0] s1, s2, im;
        logic [5:0]  ct;
        logic [2:0]  de;
        logic        ok;
        s1 = readReg(instr_in[8:6]);
        s2 = 16'h0; im = 16'h0; ct = 6'h0; de = instr_in[11:9]; ok = 1'b1;
        case (instr_in[15:12])
          4'b0001, 4'b0101: begin
            if (instr_in[5]) begin
              im = signExt({11'b0, instr_in[4:0]}, 5);
              ct = 6'b011000;
            end else begin
              s2 = readReg(instr_in[2:0]);
              ct = 6'b010000;
            end
            if (instr_in[15:12] == 4'b0101) ct = ct + 6'd1;
          end
          4'b1001: ct = 6'b010010;
          4'b1101: begin
            im = {12'b0, instr_in[3:0]};
            ct = 6'b001000 + {4'b0, instr_in[5:4]};
          end
          4'b0110: begin
            im = signExt({10'b0, instr_in[5:0]}, 6);
            ct = 6'b101000;
          end
          4'b0111: begin
            im = signExt({10'b0, instr_in[5:0]}, 6);
            s2 = readReg(instr_in[11:9]);
            ct = 6'b111000;
            de = 3'd0;
          end
          default: ok = 1'b0;
        endcase
        if (!ok) begin
          s1 = '0; s2 = '0; im = '0; ct = '0; de = '0;
          mIll = 1'b1;
        end
        mSrc1 = s1; mSrc2 = s2; mImm = im; mCtrl = ct; mDest = de; mEn = ok;
      end else if (!stall) begin
        mEn = 1'b0;
      end
      if (wb_en) mRegs[wb_addr] = wb_data;
    end
  end

  // compare process: outputs are stable at the falling edge
  always @(negedge clock) begin
    if (modelLive) begin
      chk("src1", src1, mSrc1);
      chk("src2", src2, mSrc2);
      chk("imm", imm, mImm);
      chk("control_in", 16'(control_in), 16'(mCtrl));
      chk("dest_addr", 16'(dest_addr), 16'(mDest));
      chk("enable_ex", 16'(enable_ex), 16'(mEn));
      chk("illegal_op", 16'(illegal_op), 16'(mIll));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rst, input logic [15:0] ins, input logic v,
                       input logic st, input logic we, input logic [2:0] wa,
                       input logic [15:0] wd);
    @(negedge clock);
    reset       = rst;
    instr_in    = ins;
    instr_valid = v;
    stall       = st;
    wb_en       = we;
    wb_addr     = wa;
    wb_data     = wd;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
  endtask

  task automatic issue(input logic [15:0] ins);
    drive(1'b0, ins, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000);
  endtask

  task automatic wb(input logic [2:0] a, input logic [15:0] d);
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, a, d);
  endtask

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    drive(1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    drive(1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    idle();
    chk("lit reset enable_ex", 16'(enable_ex), 16'h0);
    chk("lit reset illegal_op", 16'(illegal_op), 16'h0);
    chk("lit reset src1", src1, 16'h0);

    wb(3'd1, 16'h0005);
    wb(3'd2, 16'h0003);
    wb(3'd5, 16'hBEEF);
    wb(3'd3, 16'h7777);

    issue(16'h1642); idle();
    chk("lit add src1", src1, 16'h0005);
    chk("lit add src2", src2, 16'h0003);
    chk("lit add ctrl", 16'(control_in), 16'h0010);
    chk("lit add dest", 16'(dest_addr), 16'h3);
    chk("lit add en", 16'(enable_ex), 16'h1);

    issue(16'h167F); idle();
    chk("lit addi imm", imm, 16'hFFFF);
    chk("lit addi ctrl", 16'(control_in), 16'h0018);

    issue(16'hD864); idle();
    chk("lit sra imm", imm, 16'h0004);
    chk("lit sra ctrl", 16'(control_in), 16'h000A);
    chk("lit sra dest", 16'(dest_addr), 16'h4);

    issue(16'h7A60); idle();
    chk("lit str src2", src2, 16'hBEEF);
    chk("lit str imm", imm, 16'hFFE0);
    chk("lit str ctrl", 16'(control_in), 16'h0038);
    chk("lit str dest", 16'(dest_addr), 16'h0);

    // writeback in the same cycle as an ADD reading R1
    drive(1'b0, 16'h1642, 1'b1, 1'b0, 1'b1, 3'd1, 16'h1234); idle();
`ifdef DECODE_WB_BYPASS_EN
    chk("lit bypass src1", src1, 16'h1234);
`else
    chk("lit bypass src1", src1, 16'h0005);
`endif
    issue(16'h1642); idle();
    chk("lit after wb src1", src1, 16'h1234);

    issue(16'h6A7F);
    issue(16'h9A40);
    issue(16'h5A6F); idle();
    chk("lit andi imm", imm, 16'h000F);
    chk("lit andi ctrl", 16'(control_in), 16'h0019);

    // stall three cycles with a new instruction offered and a write pending
    issue(16'h1642);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 16'h5A6F, 1'b1, 1'b1, 1'b1, 3'd2, 16'h00AA);
      chk("lit stall ctrl", 16'(control_in), 16'h0010);
      chk("lit stall src2", src2, 16'h0003);
      chk("lit stall en", 16'(enable_ex), 16'h1);
    end
    idle(); idle();
    chk("lit idle en", 16'(enable_ex), 16'h0);
    chk("lit idle ctrl hold", 16'(control_in), 16'h0010);
    issue(16'h1642); idle();
    chk("lit stall wb src2", src2, 16'h00AA);

    // illegal opcode, then a legal one: flag stays set
    issue(16'hF000); idle();
    chk("lit ill en", 16'(enable_ex), 16'h0);
    chk("lit ill flag", 16'(illegal_op), 16'h1);
    chk("lit ill src1", src1, 16'h0);
    chk("lit ill ctrl", 16'(control_in), 16'h0);
    issue(16'h1642); idle();
    chk("lit ill sticky", 16'(illegal_op), 16'h1);
    chk("lit post ill en", 16'(enable_ex), 16'h1);

    // reset mid-stream with an instruction in flight
    issue(16'h1642);
    drive(1'b1, 16'h1642, 1'b1, 1'b0, 1'b1, 3'd3, 16'h5555);
    chk("lit pre-reset en", 16'(enable_ex), 16'h1);
    drive(1'b1, 16'h1642, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
    idle();
    chk("lit mid reset en", 16'(enable_ex), 16'h0);
    chk("lit mid reset ill", 16'(illegal_op), 16'h0);
    chk("lit mid reset src1", src1, 16'h0);
    chk("lit mid reset ctrl", 16'(control_in), 16'h0);
    issue(16'h1CC3); idle();
    chk("lit r3 cleared src1", src1, 16'h0);
    chk("lit r3 cleared src2", src2, 16'h0);
    chk("lit r3 read en", 16'(enable_ex), 16'h1);

    idle(); idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
